load_store_unit: RTL and testbench

Initiator side of the data-memory port: accepts one load or store request at a time from the execute/memory stage and drives the word-addressed `DataMem` interface (`d_r_en`, `d_w_en`, `d_add`, `data_in`, `d_out`). It supports RV32 sub-word accesses:

- Loads: byte/halfword extraction with sign or zero extension.
- Sub-word stores: read-modify-write.
- Errors: misaligned accesses are rejected with an error response.

It sits between the pipeline's MEM stage and the data memory.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 43 ++++
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned ERR_ALIGN = 0;
  localparam int unsigned ERR_RANGE = 1;

  // Misaligned address or a width code that is illegal for this direction.
  function automatic logic lsu_bad_access(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:         bad = 1'b0;
      F3_BU:        bad = we;
      F3_H:         bad = addr_lo[0];
      F3_HU:        bad = we | addr_lo[0];
      F3_W:         bad = (addr_lo != 2'b00);
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane extraction and sub-word store merge (combinational).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] d_out,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane and extend it to a full word.
  always_comb begin
    byte_sel  = d_out[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? d_out[31:16] : d_out[15:0];
    load_data = d_out;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h000000, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0000, half_sel};
      default: load_data = d_out;
    endcase
  end

  // Overlay the store data on the word read back, keeping the other lanes.
  always_comb begin
    store_word = d_out;
    case (funct3)
      F3_B: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for the word-addressed
// data memory. Optional range checking is enabled by defining LSU_BOUNDS_CHECK_EN.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        d_r_en,
  output logic        d_w_en,
  output logic [31:0] d_add,
  output logic [31:0] data_in,
  input  logic [31:0] d_out
);

  import lsu_pkg::*;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  lsu_state_t  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [1:0]  err_q;
  logic [1:0]  req_err;
  logic [31:0] word_idx;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign word_idx = {2'b00, addr_q[31:2]};

  lsu_align u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .d_out      (d_out),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Classify the incoming request; the range bit stays 0 unless checking is built in.
  always_comb begin
    req_err            = '0;
    req_err[ERR_ALIGN] = lsu_bad_access(req_we, req_funct3, req_addr[1:0]);
    req_err[ERR_RANGE] = BOUNDS_EN & ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  end

  // Request sequencing: latch, optional read, capture/merge, optional write, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_err;
            data_q  <= req_wdata;
            if (req_err != 2'b00)                  state <= ST_DONE;
            else if (req_we && req_funct3 == F3_W) state <= ST_WRITE;
            else                                   state <= ST_READ;
          end
        end
        ST_READ: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (we_q) begin
            data_q <= store_word;
            state  <= ST_WRITE;
          end else begin
            data_q <= load_data;
            state  <= ST_DONE;
          end
        end
        ST_WRITE: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Decode state into the port outputs; everything is held low during reset.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = '0;
    d_r_en     = 1'b0;
    d_w_en     = 1'b0;
    d_add      = '0;
    data_in    = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: req_ready = 1'b1;
        ST_READ: begin
          d_r_en = 1'b1;
          d_add  = word_idx;
        end
        ST_WRITE: begin
          d_w_en  = 1'b1;
          d_add   = word_idx;
          data_in = data_q;
        end
        ST_DONE: begin
          resp_valid = 1'b1;
          resp_err   = err_q;
          if (!we_q && err_q == 2'b00) resp_rdata = data_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks against a spec-level model.
module tb_load_store_unit;

  localparam int unsigned MW    = 100;
  localparam int unsigned TBMEM = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        d_r_en;
  logic        d_w_en;
  logic [31:0] d_add;
  logic [31:0] data_in;
  logic [31:0] d_out;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .d_r_en     (d_r_en),
    .d_w_en     (d_w_en),
    .d_add      (d_add),
    .data_in    (data_in),
    .d_out      (d_out)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory behaviour and access monitor.
  logic [31:0] mem [TBMEM];
  logic [31:0] ref_mem [TBMEM];
  logic        bd_en = 1'b0;
  int unsigned bd_idx = 0;
  logic [31:0] bd_val = '0;
  int unsigned rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [31:0] last_rd_add = '0, last_wr_add = '0, last_wr_data = '0;

  always @(posedge clk) begin
    if (bd_en) mem[bd_idx] <= bd_val;
    if (d_r_en) begin
      rd_cnt++;
      last_rd_add = d_add;
      d_out <= (d_add < TBMEM) ? mem[d_add] : 32'h0;
    end
    if (d_w_en) begin
      wr_cnt++;
      last_wr_add  = d_add;
      last_wr_data = data_in;
      if (d_add < TBMEM) mem[d_add] <= data_in;
    end
    if (d_r_en && d_w_en) both_cnt++;
  end

  task automatic poke(input int unsigned idx, input logic [31:0] val);
    @(negedge clk);
    bd_en = 1'b1; bd_idx = idx; bd_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic wait_ready();
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // One request against the reference model: result, error, latency and memory effects.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] obs_rd);
    int unsigned idx, exp_lat, exp_rds, exp_wrs, lat, rd0, wr0, sh;
    logic [31:0] w, b, mask, exp_rd, exp_word;
    logic [1:0]  exp_err, obs_err;
    logic        illegal, mis, oob, got;

    idx     = addr >> 2;
    illegal = (f3 == 3 || f3 == 6 || f3 == 7) || (we && (f3 == 4 || f3 == 5));
    mis     = ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) || (f3 == 2 && (addr % 4 != 0));
    oob     = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
    oob = (idx >= MW);
`endif
    exp_err  = {oob, illegal | mis};
    w        = ref_mem[idx];
    sh       = 8 * (addr % 4);
    exp_rd   = 0;
    exp_word = w;
    if (exp_err != 0) begin
      exp_lat = 1; exp_rds = 0; exp_wrs = 0;
    end else if (!we) begin
      exp_lat = 3; exp_rds = 1; exp_wrs = 0;
      if (f3 == 0 || f3 == 4) begin
        b = (w >> sh) & 32'hFF;
        exp_rd = (f3 == 0 && b >= 128) ? b - 32'd256 : b;
      end else if (f3 == 1 || f3 == 5) begin
        b = (w >> sh) & 32'hFFFF;
        exp_rd = (f3 == 1 && b >= 32768) ? b - 32'd65536 : b;
      end else begin
        exp_rd = w;
      end
    end else if (f3 == 2) begin
      exp_lat = 2; exp_rds = 0; exp_wrs = 1;
      exp_word = wd;
    end else begin
      exp_lat = 4; exp_rds = 1; exp_wrs = 1;
      mask = ((f3 == 0) ? 32'hFF : 32'hFFFF) << sh;
      exp_word = (w & ~mask) | ((wd << sh) & mask);
    end

    wait_ready();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; got = 1'b0; obs_rd = '0; obs_err = '0;
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        got = 1'b1; obs_rd = resp_rdata; obs_err = resp_err;
      end
    end
    if (!got) lat = 99;
    check("latency", lat, exp_lat);
    check("rdata", obs_rd, exp_rd);
    check("err", 32'(obs_err), 32'(exp_err));
    check("reads", rd_cnt - rd0, exp_rds);
    check("writes", wr_cnt - wr0, exp_wrs);
    if (exp_rds != 0) check("rd_add", last_rd_add, idx);
    if (exp_wrs != 0) begin
      check("wr_add", last_wr_add, idx);
      check("wr_data", last_wr_data, exp_word);
      ref_mem[idx] = exp_word;
    end
    check("mem_word", mem[idx], ref_mem[idx]);
    @(negedge clk);
    check("pulse_len", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, addr;
    logic [2:0]  f3;
    logic        we, got;
    int unsigned wr0;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < int'(TBMEM); i++) poke(i, $urandom);

    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_d_r_en", 32'(d_r_en), 32'd0);
    check("rst_d_w_en", 32'(d_w_en), 32'd0);
    check("rst_d_add", d_add, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Directed loads from word 5.
    poke(5, 32'h8765_4321);
    do_req(1'b0, 3'b010, 32'h14, '0, rd); check("lw_const", rd, 32'h8765_4321);
    do_req(1'b0, 3'b000, 32'h17, '0, rd); check("lb_const", rd, 32'hFFFF_FF87);
    do_req(1'b0, 3'b100, 32'h17, '0, rd); check("lbu_const", rd, 32'h0000_0087);
    do_req(1'b0, 3'b001, 32'h16, '0, rd); check("lh_const", rd, 32'hFFFF_8765);

    // Sub-word store merge.
    poke(2, 32'hAABB_CCDD);
    do_req(1'b1, 3'b000, 32'h09, 32'h11, rd);
    check("sb_const", mem[2], 32'hAABB_11DD);

    // Error responses.
    do_req(1'b0, 3'b010, 32'h0A, '0, rd);
    do_req(1'b1, 3'b001, 32'h03, 32'h1234, rd);
    do_req(1'b0, 3'b011, 32'h20, '0, rd);
    do_req(1'b1, 3'b100, 32'h20, 32'h55, rd);

    // Reset during the write phase of a SW.
    poke(3, 32'h0123_4567);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0C; req_wdata = 32'hDEAD_BEEF;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    got = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    check("rstmid_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    if (resp_valid) got = 1'b1;
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_no_resp", 32'(got), 32'd0);
    check("rstmid_no_write", wr_cnt - wr0, 32'd0);
    check("rstmid_word3", mem[3], 32'h0123_4567);

    // Word 100: range error or pass-through depending on build.
    do_req(1'b0, 3'b010, 32'h190, '0, rd);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      do_req(we, f3, addr, $urandom, rd);
    end

    check("rd_wr_overlap", both_cnt, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
